uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Arbitrated UART transmit scheduler. It shares one serial TX line between NREQ byte-stream requesters and grants them in round-robin order. A requester holds the line across a multi-byte packet until it marks its last byte. Bit timing is paced entirely by the `txclk_en` strobe from the baud rate generator, and the block frames each byte as 8N1 or 8N2.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..16.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.

Ports:
- `clk`, in, 1: system clock. This is the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `txclk_en`, in, 1: one-cycle bit strobe from the baud generator.
- `req_valid`, in, NREQ: bit i means requester i has a byte.
- `req_data`, in, 8*NREQ: byte for requester i at bits [8i+7:8i].
- `req_last`, in, NREQ: bit i means this byte ends requester i's packet.
- `req_ready`, out, NREQ: one-hot or zero. Bit i means the byte from requester i is accepted this cycle.
- `tx`, out, 1: serial line, registered, idles high.
- `busy`, out, 1: a frame is being shifted.
- `owner_valid`, out, 1: the packet lock is held.
- `owner_id`, out, $clog2(NREQ): the lock holder, or the most recent grant.

## Operation
- FSM states:
  - IDLE: shifter empty.
  - SHIFT: frame in progress.
- Frame width FB = 9 + STOP_BITS. The shift register holds {STOP_BITS ones, data[7:0], 0} and shifts out LSB first.
- Eligibility:
  - When `owner_valid`=1, only `owner_id` is eligible.
  - Otherwise every i with `req_valid[i]`=1 is eligible.
- Winner: the first eligible index scanning from (`last_grant`+1) mod NREQ upward, with wrap.
- `req_ready[winner]`=1 combinationally, only in IDLE. Ready may depend on valid. A requester must not drop valid or change data/last once valid is asserted until ready.
- Accept cycle (IDLE, valid&ready):
  - load the frame;
  - bit counter ← 0;
  - `last_grant` ← winner;
  - `owner_id` ← winner;
  - `owner_valid` ← !`req_last[winner]`;
  - go to SHIFT.
- SHIFT, on each `txclk_en`:
  - `tx` ← frame LSB;
  - shift right, filling with 1;
  - counter++.
  - When the counter reaches FB (the last stop bit is being driven), return to IDLE.
  - `tx` keeps its value (1) until the next frame's start bit.
- `txclk_en` during the accept cycle is ignored. Only strobes on later cycles advance the frame.
- `busy` = (state == SHIFT).
- No lock timeout. A lock holder that stops sending stalls all other requesters, by design.
- Values after `rst` (next edge, mid-frame included):
  - `tx`=1;
  - state IDLE;
  - counter 0;
  - `owner_valid`=0;
  - `owner_id`=0;
  - `last_grant`=NREQ-1, so requester 0 wins first;
  - `req_ready`=0 while `rst` is high;
  - `busy`=0.
  - A frame in progress is abandoned with no further bits.

## Timing
- Accept to start bit: `tx` falls in the cycle after the first `txclk_en` strictly after the accept cycle.
- Each bit lasts exactly one strobe period.
- Stop-bit duration is at least STOP_BITS strobe periods. A back-to-back accept happens in the first IDLE cycle, and the next start bit appears only on the following strobe.
- Maximum throughput is one byte per FB strobes, with zero idle bits between frames.
- Next-byte readiness: `req_ready` can rise at the earliest one cycle after the strobe that drives the last stop bit.
- A lock release and a new grant never share a cycle. The byte with last=1 completes its frame before the next arbitration.
- Simultaneous valid from all requesters with no lock: exactly one ready, chosen by round-robin order.

## Test plan
- Single byte, STOP_BITS=1, `txclk_en` every 4 cycles, requester 0 sends 0xA5 with last=1:
  - `tx` bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles;
  - `busy` falls after 10 strobes;
  - `owner_valid` stays 0.
- Round-robin: all four requesters hold valid with last=1 and bytes 0x10,0x11,0x12,0x13, repeated:
  - grant order is 0,1,2,3,0,…;
  - frames are back-to-back with exactly one stop-bit period between them.
- Packet lock: requester 2 sends 0x01(last=0), 0x02(last=0), 0x03(last=1) while requester 0 holds valid:
  - requester 0 gets no ready until 0x03 is accepted;
  - `owner_valid`=1 across the packet;
  - requester 0 is granted next.
- STOP_BITS=2, byte 0xFF: 11-bit frame is 0, eight 1s, two 1s. The next start bit comes no earlier than 11 strobes after the first start bit.
- Reset mid-frame: assert `rst` for one cycle after the 4th strobe of a frame:
  - `tx`=1, `busy`=0, `owner_valid`=0 on the next edge;
  - no further bits are emitted;
  - the next grant goes to requester 0.
- Strobe coincident with accept: `txclk_en` high in the accept cycle produces no start bit. The start bit appears only after the next strobe.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin arbitrated UART transmitter: NREQ byte streams share one 8N1/8N2 line,
// and a requester keeps the grant across a packet until it sends a byte marked last.
module uart_tx_sched #(
  parameter int NREQ      = 4,
  parameter int STOP_BITS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    txclk_en,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx,
  output logic                    busy,
  output logic                    owner_valid,
  output logic [$clog2(NREQ)-1:0] owner_id
);
  localparam int IW = $clog2(NREQ);
  localparam int FB = 9 + STOP_BITS;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]    state;
  logic [FB-1:0] shreg;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] last_grant;
  logic          found;
  logic [IW-1:0] winner;
  logic [IW:0]   cand;
  logic          accept;

  // Scan from last_grant+1 upward with wrap; a held lock narrows eligibility to its owner.
  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_grant} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!found && req_valid[cand[IW-1:0]] &&
          (!owner_valid || cand[IW-1:0] == owner_id)) begin
        found  = 1'b1;
        winner = cand[IW-1:0];
      end
    end
  end

  assign accept = (state == S_IDLE) && found && !rst;
  assign busy   = (state == S_SHIFT);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tx          <= 1'b1;
      shreg       <= '1;
      bit_cnt     <= '0;
      owner_valid <= 1'b0;
      owner_id    <= '0;
      last_grant  <= IW'(NREQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            shreg       <= {{STOP_BITS{1'b1}}, req_data[{winner, 3'b000} +: 8], 1'b0};
            bit_cnt     <= '0;
            last_grant  <= winner;
            owner_id    <= winner;
            owner_valid <= !req_last[winner];
            state       <= S_SHIFT;
          end
        end
        default: begin
          // A strobe in the accept cycle is ignored; only later strobes move the frame.
          if (txclk_en) begin
            tx      <= shreg[0];
            shreg   <= {1'b1, shreg[FB-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'(FB - 1)) state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a transaction-level model (grant rule, frame bit list,
// strobe counting) predicts ready, tx, busy and lock outputs every cycle.
module tb_uart_tx_sched;
  localparam int NREQ = 4;
  localparam int FB   = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              txclk_en = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   req_ready;
  logic              tx, busy, owner_valid;
  logic [1:0]        owner_id;

  logic [NREQ-1:0]   req_valid2 = '0;
  logic [8*NREQ-1:0] req_data2 = '0;
  logic [NREQ-1:0]   req_last2 = '0;
  logic [NREQ-1:0]   req_ready2;
  logic              tx2, busy2, owner_valid2;
  logic [1:0]        owner_id2;

  uart_tx_sched #(.NREQ(NREQ), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .txclk_en(txclk_en),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx(tx), .busy(busy),
    .owner_valid(owner_valid), .owner_id(owner_id)
  );

  uart_tx_sched #(.NREQ(NREQ), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .txclk_en(txclk_en),
    .req_valid(req_valid2), .req_data(req_data2), .req_last(req_last2),
    .req_ready(req_ready2), .tx(tx2), .busy(busy2),
    .owner_valid(owner_valid2), .owner_id(owner_id2)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit        m_idle = 1'b1;
  bit        m_lock = 1'b0;
  int        m_owner = 0;
  int        m_lg = NREQ - 1;
  bit        m_tx = 1'b1;
  logic [7:0] m_data = '0;
  int        m_bits = 0;

  // Stimulus state: per-requester queues of {last, data}
  logic [8:0] q [NREQ][$];
  logic [7:0] q2[$];
  bit         log2[$];
  bit  eager = 1'b1;
  bit  mon2 = 1'b0;
  bit  rst_next = 1'b0;
  bit  rst_armed = 1'b0;
  bit  rand_rst = 1'b0;
  int  period = 4;
  int  scnt = 0;

  function automatic int model_winner();
    for (int k = 1; k <= NREQ; k++) begin
      int idx = (m_lg + k) % NREQ;
      if (req_valid[idx] && (!m_lock || idx == m_owner)) return idx;
    end
    return -1;
  endfunction

  task automatic cycle();
    int w;
    logic [NREQ-1:0] exp_rdy;
    bit acc2, strobe;
    @(negedge clk);
    w = model_winner();
    exp_rdy = '0;
    if (!rst && m_idle && w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (rst || !m_idle) w = -1;
    acc2   = req_ready2[1] && req_valid2[1];
    strobe = txclk_en;
    @(posedge clk);
    if (rst) begin
      m_idle = 1'b1; m_lock = 1'b0; m_owner = 0; m_lg = NREQ - 1; m_tx = 1'b1; m_bits = 0;
    end else if (w >= 0) begin
      m_idle  = 1'b0;
      m_bits  = 0;
      m_data  = req_data[8*w +: 8];
      m_lg    = w;
      m_owner = w;
      m_lock  = !req_last[w];
    end else if (!m_idle && strobe) begin
      // Frame bit k: 0 = start, 1..8 = data LSB first, rest = stop
      m_tx = (m_bits == 0) ? 1'b0 : (m_bits <= 8) ? m_data[m_bits-1] : 1'b1;
      m_bits++;
      if (m_bits == FB) m_idle = 1'b1;
    end
    #1;
    check("tx", 32'(tx), 32'(m_tx));
    check("busy", 32'(busy), 32'(!m_idle));
    check("owner_valid", 32'(owner_valid), 32'(m_lock));
    check("owner_id", 32'(owner_id), 32'(m_owner));
    if (mon2 && strobe) log2.push_back(tx2);

    if (w >= 0) begin
      void'(q[w].pop_front());
      req_valid[w] = 1'b0;
    end
    if (acc2) begin
      void'(q2.pop_front());
      req_valid2[1] = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!req_valid[i]) begin
        if (q[i].size() > 0 && (eager || $urandom_range(0, 2) == 0)) begin
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = q[i][0][7:0];
          req_last[i]         = q[i][0][8];
        end else begin
          req_data[8*i +: 8]  = 8'($urandom);
        end
      end
    end
    if (!req_valid2[1] && q2.size() > 0) begin
      req_valid2[1]    = 1'b1;
      req_data2[15:8]  = q2[0];
      req_last2[1]     = 1'b1;
    end
    if (period == 0) txclk_en = ($urandom_range(0, 2) == 0);
    else             txclk_en = ((scnt % period) == period - 1);
    scnt++;
    rst = rst_next || (rand_rst && $urandom_range(0, 499) == 0);
    rst_next = 1'b0;
    if (rst_armed && !m_idle && m_bits == 4) begin
      rst = 1'b1;
      rst_armed = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_next = 1'b1;
    cycle();
    cycle();
  endtask

  task automatic drain(input int limit);
    int n = 0;
    bit pending;
    do begin
      cycle();
      n++;
      pending = !m_idle;
      for (int i = 0; i < NREQ; i++) if (q[i].size() > 0) pending = 1'b1;
    end while (pending && n < limit);
    check("drained", 32'(pending), 32'(0));
  endtask

  initial begin
    int f, g, n;
    cycle();
    cycle();

    // Single byte 0xA5, strobe every 4 cycles
    period = 4;
    q[0].push_back({1'b1, 8'hA5});
    drain(300);

    // Round-robin: all four requesters, two rounds
    do_reset();
    period = 2;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) q[i].push_back({1'b1, 8'(8'h10 + i)});
    drain(1000);

    // Packet lock: requester 2 holds the line while requester 0 waits
    do_reset();
    period = 3;
    q[2].push_back({1'b0, 8'h01});
    q[2].push_back({1'b0, 8'h02});
    q[2].push_back({1'b1, 8'h03});
    cycle();
    cycle();
    q[0].push_back({1'b1, 8'h55});
    drain(600);

    // Strobe every cycle: every accept coincides with a strobe
    do_reset();
    period = 1;
    q[1].push_back({1'b1, 8'h3C});
    q[3].push_back({1'b0, 8'hC3});
    q[3].push_back({1'b1, 8'h81});
    drain(200);

    // Reset after the 4th strobe of a locked frame; requester 0 must win next
    do_reset();
    period = 2;
    q[1].push_back({1'b0, 8'h3C});
    q[1].push_back({1'b1, 8'h77});
    cycle();
    cycle();
    q[0].push_back({1'b1, 8'h5A});
    rst_armed = 1'b1;
    drain(500);

    // Two stop bits, back-to-back 0xFF bytes on the second instance
    do_reset();
    period = 3;
    mon2 = 1'b1;
    log2.delete();
    q2.push_back(8'hFF);
    q2.push_back(8'hFF);
    n = 0;
    do begin
      cycle();
      n++;
    end while ((q2.size() > 0 || busy2) && n < 300);
    for (int k = 0; k < 6; k++) cycle();
    mon2 = 1'b0;
    f = -1;
    g = -1;
    foreach (log2[k]) begin
      if (log2[k] == 1'b0) begin
        if (f < 0) f = k;
        else if (g < 0) g = k;
      end
    end
    check("sb2_start_found", 32'(f >= 0), 32'(1));
    check("sb2_gap", 32'(g - f), 32'(11));
    if (f >= 0 && log2.size() >= f + 22) begin
      for (int k = 0; k < 22; k++)
        check("sb2_bit", 32'(log2[f+k]), 32'((k == 0 || k == 11) ? 0 : 1));
    end else begin
      check("sb2_len", 32'(log2.size()), 32'(f + 22));
    end
    check("sb2_busy_end", 32'(busy2), 32'(0));

    // Randomized traffic with random strobes, valid timing and resets
    do_reset();
    eager = 1'b0;
    period = 0;
    rand_rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        int i = $urandom_range(0, NREQ - 1);
        if (q[i].size() == 0) begin
          int len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) q[i].push_back({1'(b == len - 1), 8'($urandom)});
        end
      end
      cycle();
    end
    rand_rst = 1'b0;
    drain(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
